ddr_cmd_scheduler: RTL
======================

Name: ddr_cmd_scheduler

Overview:
Sits in the sclk domain between the popped read/write command FIFO outputs and the Lattice DDR3 controller's local command port. It arbitrates read and write requests round-robin and gates writes until enough write data is buffered. It drives the cmd_valid/cmd_rdy handshake and paces write data on datain_rdy. It tracks outstanding reads in a tag FIFO so that every read_data_valid beat is labelled with its AXI ID and a last flag.

Parameters:
ID_WIDTH, 4, AXI ID width carried per request
ADDR_WIDTH, 27, DDR local address width (bank+row+col)
BEATS_PER_BURST, 2, local data words moved per cmd_burst_cnt unit
RD_TAG_DEPTH, 4, maximum outstanding read commands (power of 2)

Ports:
sclk  in  1  controller system clock
rstn  in  1  synchronous, active-low reset
init_done  in  1  DDR controller initialisation complete
wr_req_valid  in  1  write request pending
wr_req_ready  out  1  write request consumed (1-cycle pulse)
wr_req_addr  in  ADDR_WIDTH  write DDR address
wr_req_len  in  4  write burst count minus 1
wr_req_id  in  ID_WIDTH  write AXI ID
rd_req_valid  in  1  read request pending
rd_req_ready  out  1  read request consumed (1-cycle pulse)
rd_req_addr  in  ADDR_WIDTH  read DDR address
rd_req_len  in  4  read burst count minus 1
rd_req_id  in  ID_WIDTH  read AXI ID
wdata_level  in  8  words currently in the write-data FIFO (sclk-side count)
ddr_cmd  out  4  0001 READ, 0010 WRITE
ddr_addr  out  ADDR_WIDTH  command address
ddr_burst_cnt  out  5  burst count, 1..16
ddr_cmd_valid  out  1  command valid
ddr_cmd_rdy  in  1  controller accepts command
ddr_datain_rdy  in  1  controller consumes one write word
ddr_read_data_valid  in  1  controller returns one read word
rd_beat_valid  out  1  read beat tag valid (same cycle as read_data_valid)
rd_beat_id  out  ID_WIDTH  AXI ID of the current read beat
rd_beat_last  out  1  final beat of that read command
busy  out  1  state is not IDLE, or reads are outstanding
err  out  2  sticky: [0] write underrun, [1] orphan read beat

Behaviour:
- Reset: state WAIT_INIT. All outputs 0, ddr_cmd = 0000, tag FIFO empty, err = 00. A reset asserted mid-operation aborts everything; ddr_cmd_valid is low on the next edge.
- WAIT_INIT: stays until init_done = 1, then moves to IDLE. No request is consumed before that. init_done is treated as sticky once seen.
- Write eligibility: wr_req_valid and wdata_level >= (wr_req_len+1)*BEATS_PER_BURST.
- Read eligibility: rd_req_valid and the tag FIFO is not full.
- IDLE, one eligible: grant it.
- IDLE, both eligible: grant the opposite of last_grant (reset value = write, so read goes first).
- On grant: the matching *_req_ready pulses for exactly 1 cycle; addr/id/len are latched; last_grant is updated; next state is ISSUE.
- ISSUE: ddr_cmd_valid = 1, with ddr_cmd, ddr_addr and ddr_burst_cnt = len+1 held stable.
  - On ddr_cmd_rdy = 1 at the edge, ddr_cmd_valid drops next cycle.
  - Read: push {id, beats = (len+1)*BEATS_PER_BURST} into the tag FIFO, then go to IDLE.
  - Write: load wcnt = (len+1)*BEATS_PER_BURST, then go to WR_DATA.
  - No timeout.
- WR_DATA: each ddr_datain_rdy decrements wcnt. When wcnt reaches 0, go to IDLE.
  - If ddr_datain_rdy arrives while wdata_level = 0, set err[0].
  - datain_rdy outside WR_DATA is ignored for counting but still flags err[0] if wdata_level = 0.
- Read tagging (independent of the FSM):
  - On ddr_read_data_valid with the tag FIFO non-empty: rd_beat_valid = 1, rd_beat_id = head id, and the head beat counter decrements.
  - rd_beat_last = 1 when the remaining count = 1; the head is popped on that beat.
  - With the tag FIFO empty: rd_beat_valid = 0 and err[1] is set.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - The tag outputs are combinational from the head plus read_data_valid (0 latency).
- Arithmetic: burst count is 5 bits (1..16). The beat counter width covers 16*BEATS_PER_BURST. last_grant toggles only on a grant.
- busy = (state != IDLE && state != WAIT_INIT) or tag FIFO non-empty.

Test Plan:
1. Hold init_done = 0 for 50 cycles with both requests valid -> no ready pulse and ddr_cmd_valid = 0. Raise init_done -> rd_req_ready pulses first.
2. Single write: len = 3, wdata_level = 8, cmd_rdy after 3 cycles -> ddr_cmd = 0010, burst_cnt = 4, valid held 3 cycles. Then 8 datain_rdy pulses -> IDLE, err = 00.
3. Write with wdata_level = 5, len = 3 -> no grant. Raise level to 8 -> grant within 2 cycles.
4. Both valid continuously, cmd_rdy immediate -> commands alternate R, W, R, W.
5. Four reads of len 0 (2 beats each) issued, fifth blocked (tag FIFO full) -> 8 read_data_valid beats give IDs in order, with rd_beat_last on beats 2, 4, 6, 8. After the first pop, the fifth read issues.
6. read_data_valid with no outstanding read -> rd_beat_valid = 0 and err[1] = 1 until reset. A rstn pulse during ISSUE -> ddr_cmd_valid = 0 next cycle and err = 00.

Source files
------------

// File: rtl/ddr_cmd_scheduler_if.sv
// Request-side and DDR3 local-port signals of the command scheduler.
// master = surrounding FIFOs/controller, slave = the scheduler itself.
interface ddr_cmd_scheduler_if #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 27
);
   logic                  init_done;
   logic                  wr_req_valid;
   logic                  wr_req_ready;
   logic [ADDR_WIDTH-1:0] wr_req_addr;
   logic [3:0]            wr_req_len;
   logic [ID_WIDTH-1:0]   wr_req_id;
   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [ADDR_WIDTH-1:0] rd_req_addr;
   logic [3:0]            rd_req_len;
   logic [ID_WIDTH-1:0]   rd_req_id;
   logic [7:0]            wdata_level;
   logic [3:0]            ddr_cmd;
   logic [ADDR_WIDTH-1:0] ddr_addr;
   logic [4:0]            ddr_burst_cnt;
   logic                  ddr_cmd_valid;
   logic                  ddr_cmd_rdy;
   logic                  ddr_datain_rdy;
   logic                  ddr_read_data_valid;
   logic                  rd_beat_valid;
   logic [ID_WIDTH-1:0]   rd_beat_id;
   logic                  rd_beat_last;
   logic                  busy;
   logic [1:0]            err;

   modport slave (
      input  init_done,
      input  wr_req_valid, wr_req_addr, wr_req_len, wr_req_id,
      output wr_req_ready,
      input  rd_req_valid, rd_req_addr, rd_req_len, rd_req_id,
      output rd_req_ready,
      input  wdata_level,
      output ddr_cmd, ddr_addr, ddr_burst_cnt, ddr_cmd_valid,
      input  ddr_cmd_rdy, ddr_datain_rdy, ddr_read_data_valid,
      output rd_beat_valid, rd_beat_id, rd_beat_last, busy, err
   );

   modport master (
      output init_done,
      output wr_req_valid, wr_req_addr, wr_req_len, wr_req_id,
      input  wr_req_ready,
      output rd_req_valid, rd_req_addr, rd_req_len, rd_req_id,
      input  rd_req_ready,
      output wdata_level,
      input  ddr_cmd, ddr_addr, ddr_burst_cnt, ddr_cmd_valid,
      output ddr_cmd_rdy, ddr_datain_rdy, ddr_read_data_valid,
      input  rd_beat_valid, rd_beat_id, rd_beat_last, busy, err
   );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// Round-robin read/write command scheduler for the DDR3 local command port,
// with write-data gating and a tag FIFO labelling returned read beats.
module ddr_cmd_scheduler #(
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned ADDR_WIDTH      = 27,
   parameter int unsigned BEATS_PER_BURST = 2,
   parameter int unsigned RD_TAG_DEPTH    = 4
) (
   input logic               sclk,
   input logic               rstn,
   ddr_cmd_scheduler_if.slave bus
);
   localparam int unsigned BCW = $clog2(16 * BEATS_PER_BURST + 1);
   localparam int unsigned PW  = $clog2(RD_TAG_DEPTH);
   localparam int unsigned LW  = (BCW > 8) ? BCW : 8;

   typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, WR_DATA} state_e;

   state_e                state_q, state_d;
   logic                  last_wr_q, last_wr_d;
   logic                  cmd_wr_q, cmd_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [3:0]            len_q, len_d;
   logic [BCW-1:0]        wcnt_q, wcnt_d;
   logic [1:0]            err_q;

   logic [ID_WIDTH-1:0]   tag_id_q    [RD_TAG_DEPTH];
   logic [BCW-1:0]        tag_beats_q [RD_TAG_DEPTH];
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [PW:0]           cnt_q;

   logic wr_rdy, rd_rdy, cmd_valid, push, pop;
   logic wr_elig, rd_elig, tag_full, tag_empty, beat_valid;
   logic [BCW-1:0] head_beats;

   function automatic logic [BCW-1:0] beats_of(input logic [3:0] len);
      return BCW'({1'b0, len} + 5'd1) * BCW'(BEATS_PER_BURST);
   endfunction

   assign tag_full   = (cnt_q == (PW+1)'(RD_TAG_DEPTH));
   assign tag_empty  = (cnt_q == '0);
   assign wr_elig    = bus.wr_req_valid &&
                       (LW'(bus.wdata_level) >= LW'(beats_of(bus.wr_req_len)));
   assign rd_elig    = bus.rd_req_valid && !tag_full;
   assign head_beats = tag_beats_q[rptr_q];
   assign beat_valid = bus.ddr_read_data_valid && !tag_empty;
   assign pop        = beat_valid && (head_beats == BCW'(1));

   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      cmd_wr_d  = cmd_wr_q;
      addr_d    = addr_q;
      id_d      = id_q;
      len_d     = len_q;
      wcnt_d    = wcnt_q;
      wr_rdy    = 1'b0;
      rd_rdy    = 1'b0;
      cmd_valid = 1'b0;
      push      = 1'b0;
      case (state_q)
         WAIT_INIT: if (bus.init_done) state_d = IDLE;
         IDLE: begin
            // Read wins when it is alone or when the previous grant was a write.
            if (rd_elig && (!wr_elig || last_wr_q)) begin
               rd_rdy    = 1'b1;
               cmd_wr_d  = 1'b0;
               last_wr_d = 1'b0;
               addr_d    = bus.rd_req_addr;
               id_d      = bus.rd_req_id;
               len_d     = bus.rd_req_len;
               state_d   = ISSUE;
            end else if (wr_elig) begin
               wr_rdy    = 1'b1;
               cmd_wr_d  = 1'b1;
               last_wr_d = 1'b1;
               addr_d    = bus.wr_req_addr;
               id_d      = bus.wr_req_id;
               len_d     = bus.wr_req_len;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cmd_valid = 1'b1;
            if (bus.ddr_cmd_rdy) begin
               if (cmd_wr_q) begin
                  wcnt_d  = beats_of(len_q);
                  state_d = WR_DATA;
               end else begin
                  push    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WR_DATA: begin
            if (bus.ddr_datain_rdy) begin
               wcnt_d = wcnt_q - BCW'(1);
               if (wcnt_q == BCW'(1)) state_d = IDLE;
            end
         end
         default: state_d = WAIT_INIT;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!rstn) begin
         state_q   <= WAIT_INIT;
         last_wr_q <= 1'b1;
         cmd_wr_q  <= 1'b0;
         addr_q    <= '0;
         id_q      <= '0;
         len_q     <= '0;
         wcnt_q    <= '0;
         err_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         cmd_wr_q  <= cmd_wr_d;
         addr_q    <= addr_d;
         id_q      <= id_d;
         len_q     <= len_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_q | {bus.ddr_read_data_valid && tag_empty,
                               bus.ddr_datain_rdy && (bus.wdata_level == '0)};
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Push never hits the head slot: that would need the FIFO empty (no beat) or full (no read granted).
   always_ff @(posedge sclk) begin
      if (push) begin
         tag_id_q[wptr_q]    <= id_q;
         tag_beats_q[wptr_q] <= beats_of(len_q);
      end
      if (beat_valid) tag_beats_q[rptr_q] <= head_beats - BCW'(1);
   end

   assign bus.wr_req_ready  = wr_rdy;
   assign bus.rd_req_ready  = rd_rdy;
   assign bus.ddr_cmd_valid = cmd_valid;
   assign bus.ddr_cmd       = cmd_valid ? (cmd_wr_q ? 4'b0010 : 4'b0001) : 4'b0000;
   assign bus.ddr_addr      = addr_q;
   assign bus.ddr_burst_cnt = cmd_valid ? ({1'b0, len_q} + 5'd1) : 5'd0;
   assign bus.rd_beat_valid = beat_valid;
   assign bus.rd_beat_id    = beat_valid ? tag_id_q[rptr_q] : '0;
   assign bus.rd_beat_last  = pop;
   assign bus.busy          = ((state_q != IDLE) && (state_q != WAIT_INIT)) || !tag_empty;
   assign bus.err           = err_q;
endmodule
